// File: rtl/mux_4_1_if.sv
// mux_4_1_if: data/select inputs and mux/change-detect outputs of mux_4_1
interface mux_4_1_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] i0, i1, i2, i3, out;
  logic s0, s1, sel_chg;
  logic [7:0] chg_cnt;
  modport master(output i0, i1, i2, i3, s0, s1, input out, sel_chg, chg_cnt);
  modport slave(input i0, i1, i2, i3, s0, s1, output out, sel_chg, chg_cnt);
endinterface

// File: rtl/mux_4_1.sv
// mux_4_1: 4:1 mux tree of 2:1 stages with select-change counter; MUX_4_1_OUTREG_EN registers out
module mux_4_1_mux2 #(parameter int WIDTH = 1) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

module mux_4_1 #(parameter int WIDTH = 1) (
  input logic clk,
  input logic rst,
  mux_4_1_if.slave bus
);
  logic [WIDTH-1:0] w_m0, w_m1, w_y;
  logic [1:0] w_sel, r_sel_q;
  logic w_chg, r_sel_chg;
  logic [7:0] r_chg_cnt;
  mux_4_1_mux2 #(.WIDTH(WIDTH)) u_m0 (.i_sel(bus.s0), .i_a(bus.i0), .i_b(bus.i1), .o_y(w_m0));
  mux_4_1_mux2 #(.WIDTH(WIDTH)) u_m1 (.i_sel(bus.s0), .i_a(bus.i2), .i_b(bus.i3), .o_y(w_m1));
  mux_4_1_mux2 #(.WIDTH(WIDTH)) u_m2 (.i_sel(bus.s1), .i_a(w_m0), .i_b(w_m1), .o_y(w_y));
  assign w_sel = {bus.s1, bus.s0};
  assign w_chg = w_sel != r_sel_q;
  always_ff @(posedge clk)
    if (rst) begin
      r_sel_q   <= 2'b00;
      r_sel_chg <= 1'b0;
      r_chg_cnt <= 8'd0;
    end else begin
      r_sel_q   <= w_sel;
      r_sel_chg <= w_chg;
      r_chg_cnt <= (w_chg && r_chg_cnt != 8'hff) ? r_chg_cnt + 8'd1 : r_chg_cnt;
    end
  assign bus.sel_chg = r_sel_chg;
  assign bus.chg_cnt = r_chg_cnt;
`ifdef MUX_4_1_OUTREG_EN
  logic [WIDTH-1:0] r_out;
  always_ff @(posedge clk)
    r_out <= rst ? '0 : w_y;
  assign bus.out = r_out;
`else
  assign bus.out = w_y;
`endif
endmodule

// File: tb/tb_mux_4_1.sv
// tb_mux_4_1: table-driven and sequence checks of mux_4_1 with an expected-result queue
module tb_mux_4_1;
  localparam int W = 8;
  localparam logic [4*W-1:0] DA = {8'd0, 8'd1, 8'd1, 8'd0};
  localparam logic [4*W-1:0] DB = {8'h88, 8'h44, 8'h22, 8'h11};
  typedef struct packed {
    logic [4*W-1:0] d;
    logic [1:0]     s;
    logic [W-1:0]   out;
  } vec_t;
  typedef struct packed {
    logic [W-1:0] out;
    logic         chg;
    logic [7:0]   cnt;
  } exp_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  mux_4_1_if #(.WIDTH(W)) bus();
  mux_4_1 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  vec_t tbl [8];
  exp_t q [$];
  int checks = 0, errors = 0;
  logic [1:0] m_sel = 2'd0;
  logic [7:0] m_cnt = 8'd0;

  function automatic logic [W-1:0] db_sel(input logic [1:0] s);
    return s == 2'd0 ? 8'h11 : s == 2'd1 ? 8'h22 : s == 2'd2 ? 8'h44 : 8'h88;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic apply(input logic [4*W-1:0] d, input logic [1:0] s);
    {bus.i3, bus.i2, bus.i1, bus.i0} = d;
    {bus.s1, bus.s0} = s;
  endtask

  task automatic drive(input logic [4*W-1:0] d, input logic [1:0] s, input logic [W-1:0] e_out);
    exp_t x, y;
    @(negedge clk);
    apply(d, s);
    x.out = e_out;
    x.chg = s != m_sel;
    x.cnt = (x.chg && m_cnt != 8'hff) ? m_cnt + 8'd1 : m_cnt;
    m_sel = s;
    m_cnt = x.cnt;
    q.push_back(x);
    @(posedge clk);
    #1;
    y = q.pop_front();
    chk("out", 32'(bus.out), 32'(y.out));
    chk("sel_chg", 32'(bus.sel_chg), 32'(y.chg));
    chk("chg_cnt", 32'(bus.chg_cnt), 32'(y.cnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst sel_chg", 32'(bus.sel_chg), 32'd0);
    chk("rst chg_cnt", 32'(bus.chg_cnt), 32'd0);
`ifdef MUX_4_1_OUTREG_EN
    chk("rst out", 32'(bus.out), 32'd0);
`endif
    rst = 0;
    m_sel = 2'd0;
    m_cnt = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = {DA, 2'd0, 8'd0};
    tbl[1] = {DA, 2'd1, 8'd1};
    tbl[2] = {DA, 2'd2, 8'd1};
    tbl[3] = {DA, 2'd3, 8'd0};
    tbl[4] = {DB, 2'd0, 8'h11};
    tbl[5] = {DB, 2'd1, 8'h22};
    tbl[6] = {DB, 2'd2, 8'h44};
    tbl[7] = {DB, 2'd3, 8'h88};
    apply('0, 2'd0);
    do_reset();
`ifndef MUX_4_1_OUTREG_EN
    for (int i = 0; i < 8; i++) begin
      #3;
      apply(tbl[i].d, tbl[i].s);
      #1;
      chk("comb out", 32'(bus.out), 32'(tbl[i].out));
    end
    do_reset();
`endif
    for (int i = 0; i < 8; i++) drive(tbl[i].d, tbl[i].s, tbl[i].out);
    drive({8'h01, 8'h02, 8'h04, 8'h08}, 2'd3, 8'h01);
    drive({8'hf0, 8'h0f, 8'h55, 8'haa}, 2'd3, 8'hf0);
    do_reset();
    repeat (3) drive(DB, 2'd0, 8'h11);
    drive(DB, 2'd1, 8'h22);
    drive(DB, 2'd1, 8'h22);
    drive(DB, 2'd3, 8'h88);
    chk("seq cnt", 32'(bus.chg_cnt), 32'd2);
    for (int i = 0; i < 300; i++) drive(DB, i[0] ? 2'd3 : 2'd2, i[0] ? 8'h88 : 8'h44);
    chk("sat cnt", 32'(bus.chg_cnt), 32'd255);
    drive(DB, 2'd3, 8'h88);
    chk("sat hold", 32'(bus.chg_cnt), 32'd255);
    do_reset();
    for (int i = 0; i < 17; i++) drive(DB, i[0] ? 2'd2 : 2'd3, db_sel(i[0] ? 2'd2 : 2'd3));
    chk("pre-rst cnt", 32'(bus.chg_cnt), 32'd17);
    do_reset();
    drive(DB, 2'd3, 8'h88);
    chk("post-rst chg", 32'(bus.sel_chg), 32'd1);
    chk("post-rst cnt", 32'(bus.chg_cnt), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
